// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one synchronous data RAM between the CPU core and
// the host/loader port; a CPU lock keeps read-modify-write pairs together.
module ram_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic                  cpu_lock,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ack,
  output logic                  cpu_stall,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_ack,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we,
  output logic                  ram_re,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOCKED, ST_ISSUE, ST_RESP} state_e;
  typedef enum logic {PORT_CPU = 1'b0, PORT_HOST = 1'b1} port_e;

  state_e                state_q, state_d;
  port_e                 owner_q, owner_d;
  port_e                 last_owner_q, last_owner_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;
  logic                  grant_c;
  port_e                 grant_port_c;
  logic                  issue_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= PORT_CPU;
      last_owner_q <= PORT_HOST;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  // Arbitration, lock handling and capture of the winner's request fields
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;
    grant_c      = 1'b0;
    grant_port_c = PORT_CPU;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req && host_req) begin
          grant_c      = 1'b1;
          grant_port_c = (last_owner_q == PORT_HOST) ? PORT_CPU : PORT_HOST;
        end else if (cpu_req) begin
          grant_c      = 1'b1;
          grant_port_c = PORT_CPU;
        end else if (host_req) begin
          grant_c      = 1'b1;
          grant_port_c = PORT_HOST;
        end
      end
      ST_LOCKED: begin
        if (cpu_req) begin
          grant_c      = 1'b1;
          grant_port_c = PORT_CPU;
        end else if (!cpu_lock) begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP: begin
        last_owner_d = owner_q;
        if (!we_q) begin
          if (owner_q == PORT_CPU) cpu_rdata_d = ram_rdata;
          else                     host_rdata_d = ram_rdata;
        end
        // The owner's own req is ignored here; only the other port may win
        if (owner_q == PORT_CPU && cpu_lock) begin
          state_d = ST_LOCKED;
        end else if (owner_q == PORT_CPU && host_req) begin
          grant_c      = 1'b1;
          grant_port_c = PORT_HOST;
        end else if (owner_q == PORT_HOST && cpu_req) begin
          grant_c      = 1'b1;
          grant_port_c = PORT_CPU;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (grant_c) begin
      state_d = ST_ISSUE;
      owner_d = grant_port_c;
      if (grant_port_c == PORT_HOST) begin
        we_d    = host_we;
        addr_d  = host_addr;
        wdata_d = host_wdata;
      end else begin
        we_d    = cpu_we;
        addr_d  = cpu_addr;
        wdata_d = cpu_wdata;
      end
    end
  end

  assign issue_c    = (state_q == ST_ISSUE);
  assign ram_we     = issue_c && we_q;
  assign ram_re     = issue_c && !we_q;
  assign ram_addr   = issue_c ? addr_q : '0;
  assign ram_wdata  = issue_c ? wdata_q : '0;

  assign cpu_ack    = (state_q == ST_RESP) && (owner_q == PORT_CPU);
  assign host_ack   = (state_q == ST_RESP) && (owner_q == PORT_HOST);
  // Read data passes straight through during a read ack, then holds
  assign cpu_rdata  = (cpu_ack && !we_q) ? ram_rdata : cpu_rdata_q;
  assign host_rdata = (host_ack && !we_q) ? ram_rdata : host_rdata_q;
  assign cpu_stall  = cpu_req & ~cpu_ack;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single synchronous data RAM between the CPU core and a host/loader port. The CPU side is driven by the instruction decoder's EXECUTE / EXECUTE_2 / WRITE_BACK accesses. The host side is used by the program loader and debug access. The block sequences each access through an issue cycle and a response cycle, arbitrates round-robin, and supports a CPU lock so that read-modify-write pairs (e.g. MEM_TO_MEM) are not split by host traffic.

## Interface
Parameters:
- DATA_WIDTH, 8, RAM data width.
- ADDR_WIDTH, 8, RAM address width (matches OPERAND_WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU access request; held high until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_lock  in  1  reserve the RAM for the CPU's next access; sampled in the CPU ack cycle.
- cpu_addr  in  ADDR_WIDTH  CPU address.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_rdata  out  DATA_WIDTH  CPU read data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_stall  out  1  cpu_req & ~cpu_ack (combinational); freezes the decoder FSM.
- host_req, host_we, host_addr, host_wdata  in  1/1/ADDR_WIDTH/DATA_WIDTH  same rules as the CPU port.
- host_rdata  out  DATA_WIDTH  host read data.
- host_ack  out  1  one-cycle completion pulse.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_we  out  1  RAM write strobe.
- ram_re  out  1  RAM read strobe.
- ram_rdata  in  DATA_WIDTH  RAM read data, valid one cycle after ram_re.

## Operation
- State machine:
  - IDLE: no grant outstanding.
  - LOCKED: only the CPU may be granted.
  - ISSUE: RAM signals are driven for the owner.
  - RESP: the owner's ack is asserted.
- Registered `owner` (CPU/HOST) and `last_owner` registers; `last_owner` resets to HOST.
- Arbitration runs in IDLE and RESP and selects among the eligible requests:
  - One eligible request: it wins.
  - Both eligible: the port that is not `last_owner` wins (round-robin).
  - In RESP, the current owner's req is ignored. The other port is eligible, and a win moves the FSM directly to ISSUE.
  - RESP with no eligible winner: go to IDLE.
- Lock handling:
  - cpu_lock high in a CPU RESP cycle: next state is LOCKED instead of arbitrating.
  - LOCKED with cpu_req: grant the CPU and go to ISSUE.
  - LOCKED with cpu_lock low and no cpu_req: go to IDLE.
  - Host requests wait throughout LOCKED.
  - A lock taken in the ack of the locked access chains the reservation.
- ISSUE cycle:
  - ram_addr and ram_wdata = owner's addr and wdata.
  - ram_we = owner_we; ram_re = ~owner_we.
  - Outside ISSUE, all RAM outputs are 0.
  - Next state is always RESP.
- RESP cycle:
  - Owner's ack = 1.
  - Owner's rdata = ram_rdata (combinational pass-through during a read ack). A per-port rdata register loads ram_rdata at the end of RESP, and rdata holds that value afterwards.
  - On a write, rdata is unchanged.
  - `last_owner` ← owner.
- Requester rules:
  - Fields stay stable from req rise until ack.
  - A new request may be presented from the cycle after ack.

## Timing
- Latency: req high in IDLE at cycle N, then ISSUE at N+1 and ack at N+2.
- Peak throughput: one access per 2 cycles (RESP→ISSUE back-to-back).
- A waiting port gets at most one other-port access before it is served, except under an active CPU lock.
- Reset values:
  - state = IDLE, owner = CPU, last_owner = HOST.
  - All acks = 0; cpu_rdata and host_rdata = 0.
  - ram_we, ram_re, ram_addr, ram_wdata = 0.
- Reset asserted mid-access:
  - ram_we and ram_re drop asynchronously.
  - No ack is issued.
  - The interrupted request is re-arbitrated after release if its req is still high.
- Simultaneous requests with a lock pending: the lock wins over round-robin.
- A req that drops before ack is a protocol violation. The block still completes the issued access, and the ack is then ignored by the requester.

## Test plan
- Reset: hold rst with both reqs high → all acks, ram_we, ram_re, rdata = 0; cpu_stall = 1.
- CPU write then read: write 0xA5 to 0x10, with ram_we=1 one cycle after req and cpu_ack the cycle after that; then read 0x10 → ram_re, then cpu_ack with cpu_rdata=0xA5 held afterwards.
- Tie after reset: cpu_req and host_req rise together at cycle 0 → CPU ISSUE at cycle 1, ack at 2; host ISSUE at 3, host_ack at 4.
- Lock: CPU reads 0x20 with cpu_lock=1 while host_req is pending, then writes 0x21 → host stays waiting until the CPU write ack (cpu_lock=0 in that ack); host_ack comes 2 cycles later.
- Continuous contention: both reqs re-asserted immediately after each ack for 6 accesses → grant order C,H,C,H,C,H with acks every 2 cycles.
- Reset mid-ISSUE of a host write: assert rst → ram_we falls in the same cycle and no host_ack; after release with host_req still high → the access is re-issued and completes normally.
